// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder at the far end of the pipeline's data-memory port.
// It owns a word-addressed array. Each accepted access completes after
// LATENCY wait states with a one-cycle ack. busy is high while an access is in
// flight, and the hazard unit uses it to stall F/D/E/M.
//
// Parameters:
//   DATA_WIDTH  - data word width in bits (default 32)
//   DEPTH_WORDS - number of words in the array; word index is addr[31:2]
//   LATENCY     - wait-state cycles between accept and ack, 0..15
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-low reset
//   req       in   access request, sampled on the rising edge
//   we        in   1 = write, 0 = read (qualified by req)
//   addr      in   32-bit byte address
//   wdata     in   store data
//   rdata     out  read data, valid in the ack cycle, held until the next ack
//   ack       out  one-cycle completion pulse
//   busy      out  access in flight
//   fault     out  misaligned-access flag (only with DMEM_MISALIGN_FAULT_EN)
//   state_dbg out  current FSM state (IDLE=0, WAIT=1, RESP=2)
//
// Optional feature macro: DMEM_MISALIGN_FAULT_EN
//   When defined, the fault port exists. An access with addr[1:0] != 0 raises
//   fault together with its ack. A misaligned write is dropped and a
//   misaligned read returns 0. When undefined, addr[1:0] is ignored.
//
// Handshake (req/ack): req is sampled only in IDLE and in the ack (RESP)
// cycle. Every sampled req produces exactly one ack pulse LATENCY+1 cycles
// later. req is ignored while busy; the requester holds it stable under stall.
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ack,
    output logic                  busy,
`ifdef DMEM_MISALIGN_FAULT_EN
    output logic                  fault,
`endif
    output logic [1:0]            state_dbg
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

`ifdef DMEM_MISALIGN_FAULT_EN
    localparam logic MISALIGN_EN = 1'b1;
`else
    localparam logic MISALIGN_EN = 1'b0;
`endif

    // Parameter range checks, caught at elaboration.
    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be in 0..15");
    end
    if (DEPTH_WORDS < 1) begin : g_bad_depth
        $error("dmem_responder: DEPTH_WORDS must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                state;
    logic [3:0]            cnt;

    // Holding registers for the accepted access.
    logic [29:0]           hold_idx;
    logic                  hold_we;
    logic [DATA_WIDTH-1:0] hold_wdata;
    logic                  hold_mis;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    logic [29:0]           acc_idx;
    logic                  acc_mis;
    logic                  accept;
    logic                  enter_resp;
    logic [29:0]           resp_idx;
    logic                  resp_we;
    logic                  resp_mis;
    logic                  resp_in_range;
    logic                  wr_commit;
    logic                  fwd;
    logic [DATA_WIDTH-1:0] resp_rdata;

    assign acc_idx = addr[31:2];
    assign acc_mis = MISALIGN_EN && (addr[1:0] != 2'b00);
    assign accept  = req && ((state == S_IDLE) || (state == S_RESP));

    // With zero wait states the access goes straight from accept to RESP, so
    // the response is formed from the incoming request rather than the
    // holding registers, which are only being loaded on that same edge.
    assign enter_resp = (LATENCY == 0) ? accept
                                       : ((state == S_WAIT) && (cnt == 4'd0));
    assign resp_idx   = (LATENCY == 0) ? acc_idx : hold_idx;
    assign resp_we    = (LATENCY == 0) ? we      : hold_we;
    assign resp_mis   = (LATENCY == 0) ? acc_mis : hold_mis;

    assign resp_in_range = (resp_idx < DEPTH_LIM);

    // A write commits at the end of its ack cycle. Out-of-range and
    // misaligned writes are dropped.
    assign wr_commit = (state == S_RESP) && hold_we && !hold_mis &&
                       (hold_idx < DEPTH_LIM);

    // A back-to-back read of the word being written on the same edge
    // (LATENCY = 0 only) must see the new data, so forward it.
    assign fwd = wr_commit && (hold_idx == resp_idx);

    always_comb begin
        resp_rdata = '0;
        if (resp_in_range && !resp_mis) begin
            if (fwd) begin
                resp_rdata = hold_wdata;
            end else begin
                resp_rdata = mem[resp_idx[AW-1:0]];
            end
        end
    end

    // Storage array, deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            mem[hold_idx[AW-1:0]] <= hold_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            ack        <= 1'b0;
            busy       <= 1'b0;
            rdata      <= '0;
            hold_idx   <= '0;
            hold_we    <= 1'b0;
            hold_wdata <= '0;
            hold_mis   <= 1'b0;
        end else begin
            ack <= enter_resp;
            if (enter_resp && !resp_we) begin
                rdata <= resp_rdata;
            end

            case (state)
                S_IDLE, S_RESP: begin
                    if (req) begin
                        hold_idx   <= acc_idx;
                        hold_we    <= we;
                        hold_wdata <= wdata;
                        hold_mis   <= acc_mis;
                        if (LATENCY == 0) begin
                            state <= S_RESP;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= 4'(LATENCY - 1);
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_RESP;
                        busy  <= 1'b0;
                    end else begin
                        cnt  <= cnt - 4'd1;
                        busy <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMEM_MISALIGN_FAULT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault <= 1'b0;
        end else begin
            fault <= enter_resp && resp_mis;
        end
    end
`endif

    assign state_dbg = state;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Two instances share clock and reset: u_dut2 (LATENCY = 2) and u_dut0
// (LATENCY = 0). Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- DUT signals ----------------
    logic        req2, we2, ack2, busy2;
    logic [31:0] addr2, wdata2, rdata2;
    logic [1:0]  st2;
    logic        req0, we0, ack0, busy0;
    logic [31:0] addr0, wdata0, rdata0;
    logic [1:0]  st0;
`ifdef DMEM_MISALIGN_FAULT_EN
    logic        fault2, fault0;
`endif

    int total = 0;
    int bad   = 0;

    dmem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(64), .LATENCY(2)) u_dut2 (
        .clk(clk), .reset(rst_n), .req(req2), .we(we2), .addr(addr2),
        .wdata(wdata2), .rdata(rdata2), .ack(ack2), .busy(busy2),
`ifdef DMEM_MISALIGN_FAULT_EN
        .fault(fault2),
`endif
        .state_dbg(st2)
    );

    dmem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(64), .LATENCY(0)) u_dut0 (
        .clk(clk), .reset(rst_n), .req(req0), .we(we0), .addr(addr0),
        .wdata(wdata0), .rdata(rdata0), .ack(ack0), .busy(busy0),
`ifdef DMEM_MISALIGN_FAULT_EN
        .fault(fault0),
`endif
        .state_dbg(st0)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver: one LATENCY=2 access ----------------
    // Cycle 0 presents the request, cycles 1-2 are wait states (optionally
    // with a different request toggled in), cycle 3 is the ack cycle, cycle 4
    // must show no further ack.
    task automatic access2(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp, input logic exp_fault,
                           input logic noise, input string tag);
        @(negedge clk);
        check({tag, "_c0_busy"}, {31'b0, busy2}, 32'd0);
        req2 = 1'b1; we2 = w; addr2 = a; wdata2 = d;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            check({tag, "_wait_busy"}, {31'b0, busy2}, 32'd1);
            check({tag, "_wait_ack"}, {31'b0, ack2}, 32'd0);
            req2 = noise;
            if (noise) begin
                we2 = 1'b1; addr2 = 32'h0000_003C; wdata2 = 32'hDEAD_BEEF;
            end
        end
        @(negedge clk);
        req2 = 1'b0;
        check({tag, "_ack"}, {31'b0, ack2}, 32'd1);
        check({tag, "_ack_busy"}, {31'b0, busy2}, 32'd0);
        if (!w) check({tag, "_rdata"}, rdata2, exp);
`ifdef DMEM_MISALIGN_FAULT_EN
        check({tag, "_fault"}, {31'b0, fault2}, {31'b0, exp_fault});
`else
        if (exp_fault) $display("note: %s expects a fault only with the fault feature", tag);
`endif
        @(negedge clk);
        check({tag, "_post_ack"}, {31'b0, ack2}, 32'd0);
`ifdef DMEM_MISALIGN_FAULT_EN
        check({tag, "_post_fault"}, {31'b0, fault2}, 32'd0);
`endif
    endtask

    // ---------------- LATENCY=0 vector table ----------------
    // Row k: inputs driven in cycle k; expected ack / rdata observed in
    // cycle k (result of the previous edge).
    localparam int NV = 8;
    logic        v_req  [NV] = '{1, 1, 1, 1, 1, 1, 0, 0};
    logic        v_we   [NV] = '{1, 1, 0, 0, 1, 0, 0, 0};
    logic [31:0] v_addr [NV] = '{32'h00, 32'h04, 32'h00, 32'h04, 32'h04, 32'h04, 32'h00, 32'h00};
    logic [31:0] v_wd   [NV] = '{32'hA0A0_0001, 32'hB0B0_0002, 0, 0, 32'hC0C0_0003, 0, 0, 0};
    logic        v_ack  [NV] = '{0, 1, 1, 1, 1, 1, 1, 0};
    logic        v_chk  [NV] = '{0, 0, 0, 1, 1, 1, 1, 1};
    logic [31:0] v_rd   [NV] = '{0, 0, 0, 32'hA0A0_0001, 32'hB0B0_0002, 32'hB0B0_0002,
                                 32'hC0C0_0003, 32'hC0C0_0003};

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        req2 = 0; we2 = 0; addr2 = 0; wdata2 = 0;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        repeat (2) @(negedge clk);
        check("rst_ack2",   {31'b0, ack2},  32'd0);
        check("rst_busy2",  {31'b0, busy2}, 32'd0);
        check("rst_rdata2", rdata2,         32'd0);
        check("rst_state2", {30'b0, st2},   32'd0);
        check("rst_ack0",   {31'b0, ack0},  32'd0);
        check("rst_rdata0", rdata0,         32'd0);
`ifdef DMEM_MISALIGN_FAULT_EN
        check("rst_fault2", {31'b0, fault2}, 32'd0);
`endif
        rst_n = 1'b1;

        // LATENCY=2 write then read back
        access2(1, 32'h08, 32'h1234_5678, 0, 0, 0, "l2_wr08");
        access2(0, 32'h08, 0, 32'h1234_5678, 0, 0, "l2_rd08");

        // LATENCY=0 back-to-back with req held high, including read-after-write
        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            check($sformatf("l0_ack_%0d", k), {31'b0, ack0}, {31'b0, v_ack[k]});
            check($sformatf("l0_busy_%0d", k), {31'b0, busy0}, 32'd0);
            if (v_chk[k]) check($sformatf("l0_rdata_%0d", k), rdata0, v_rd[k]);
            req0 = v_req[k]; we0 = v_we[k]; addr0 = v_addr[k]; wdata0 = v_wd[k];
        end

        // req toggled during WAIT with a different address is ignored
        access2(1, 32'h3C, 32'h3C3C_3C3C, 0, 0, 0, "nz_wr3c");
        access2(0, 32'h08, 0, 32'h1234_5678, 0, 1, "nz_rd08");
        access2(0, 32'h3C, 0, 32'h3C3C_3C3C, 0, 0, "nz_rd3c");

        // Out-of-range: dropped write, zero read, no wrap onto word 0
        access2(1, 32'h000, 32'h0000_5A5A, 0, 0, 0, "oor_wr000");
        access2(1, 32'h0FC, 32'h6363_6363, 0, 0, 0, "oor_wr0fc");
        access2(1, 32'h100, 32'hFFFF_FFFF, 0, 0, 0, "oor_wr100");
        access2(0, 32'h100, 0, 32'h0, 0, 0, "oor_rd100");
        access2(0, 32'h000, 0, 32'h0000_5A5A, 0, 0, "oor_rd000");
        access2(0, 32'h0FC, 0, 32'h6363_6363, 0, 0, "oor_rd0fc");
        access2(0, 32'hFFFF_FF00, 0, 32'h0, 0, 0, "oor_rdhigh");

        // Misaligned accesses
`ifdef DMEM_MISALIGN_FAULT_EN
        access2(1, 32'h0A, 32'hAAAA_5555, 0, 1, 0, "mis_wr0a");
        access2(0, 32'h08, 0, 32'h1234_5678, 0, 0, "mis_rd08");
        access2(0, 32'h09, 0, 32'h0, 1, 0, "mis_rd09");
`else
        access2(1, 32'h0A, 32'hAAAA_5555, 0, 0, 0, "mis_wr0a");
        access2(0, 32'h08, 0, 32'hAAAA_5555, 0, 0, "mis_rd08");
        access2(0, 32'h09, 0, 32'hAAAA_5555, 0, 0, "mis_rd09");
`endif

        // Reset during WAIT aborts the pending write
        access2(1, 32'h10, 32'h1111_2222, 0, 0, 0, "rs_wr10");
        access2(0, 32'h10, 0, 32'h1111_2222, 0, 0, "rs_rd10");
        @(negedge clk);
        req2 = 1'b1; we2 = 1'b1; addr2 = 32'h10; wdata2 = 32'hCAFE_F00D;
        @(negedge clk);
        req2 = 1'b0;
        check("rs_pre_busy", {31'b0, busy2}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rs_ack",   {31'b0, ack2},  32'd0);
        check("rs_busy",  {31'b0, busy2}, 32'd0);
        check("rs_rdata", rdata2,         32'd0);
        check("rs_state", {30'b0, st2},   32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rs_hold_ack", {31'b0, ack2}, 32'd0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("rs_noack", {31'b0, ack2}, 32'd0);
        end
        access2(0, 32'h10, 0, 32'h1111_2222, 0, 0, "rs_rd10_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
